osc_dac_spi_tx: RTL and testbench
=================================

Name: osc_dac_spi_tx

Overview:
- Downstream consumer of the harmonic oscillator's 12-bit `wave` output.
- Decimates the free-running waveform to a fixed sample rate and converts each sample to DAC code.
- Serialises each code as a 16-bit SPI frame to an MCP4921-class DAC, then pulses LDAC so the analogue output updates.
- Sits between the oscillator and the board's DAC pins.

Parameters:
- CLK_DIV, 4: SCK half-period in clk_in cycles; legal range ≥1.
- SAMPLE_DIV, 256: clk_in cycles between sample ticks; legal range ≥2.
- DAC_CONFIG, 4'b0011: frame bits [15:12] in order A/B, BUF, GA_n, SHDN_n.

Ports:
- clk_in  input  1  system clock; all logic on its rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- wave  input  12  oscillator sample, two's complement.
- enable  input  1  permits new sample captures.
- dac_cs_n  output  1  SPI chip select, active low.
- dac_sck  output  1  SPI clock, idle low.
- dac_sdi  output  1  SPI data, MSB first.
- dac_ldac_n  output  1  DAC latch strobe, active low.
- busy  output  1  high while a frame is in progress.
- sample_tick  output  1  one-cycle pulse on each capture.
- overrun  output  1  sticky flag: a sample tick was dropped.

Behaviour:
- Reset (rst_in high at a clk_in edge):
  - dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ldac_n=1, busy=0, sample_tick=0, overrun=0.
  - Tick prescaler=0; FSM=IDLE.
  - Reset mid-frame aborts immediately to these values; the DAC never sees LDAC for the aborted frame.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1 continuously, independent of enable.
  - An internal tick occurs on the cycle the count wraps to 0.
- Capture:
  - Condition: tick AND enable AND FSM=IDLE.
  - That cycle, the shift register loads {DAC_CONFIG, code}, where code is the 12-bit DAC value.
  - sample_tick=1 for that cycle; FSM goes to SHIFT.
- Overrun:
  - Tick AND enable AND FSM≠IDLE sets overrun. The sample is dropped and the frame in progress is untouched.
  - overrun clears only on reset.
- FSM states: IDLE → SHIFT → CS_HOLD → LDAC → IDLE.
- SHIFT:
  - Entered the cycle after capture. dac_cs_n=0, busy=1, dac_sdi=bit15 from the first SHIFT cycle.
  - dac_sck toggles every CLK_DIV cycles, giving 16 rising and 16 falling edges over exactly 32·CLK_DIV cycles.
  - dac_sdi advances to the next bit on each falling edge except the last; the DAC samples on rising edges.
  - Ends with dac_sck=0.
- CS_HOLD: dac_cs_n=1, dac_sck=0; lasts CLK_DIV cycles.
- LDAC: dac_ldac_n=0; lasts CLK_DIV cycles.
- Return to IDLE: busy drops on entry to IDLE.
- Busy duration: busy is high for 34·CLK_DIV cycles, starting the cycle after capture.
- Timing requirement: SAMPLE_DIV > 34·CLK_DIV. If this is violated, every other tick overruns; this is legal and must not hang the FSM.
- enable deasserted mid-frame: the current frame completes normally; no new capture occurs.
- Tick and frame end on the same cycle: the FSM is not yet IDLE on that cycle, so it counts as an overrun.
- Outputs: all are registered; no combinational path from wave to pins.

Optional Feature:
- Macro: OSC_DAC_OFFSET_EN.
- Defined: code = {~wave[11], wave[10:0]}, i.e. two's complement converted to offset binary, so 0 maps to mid-scale 0x800.
- Undefined: code = wave, passed unchanged; for callers that pre-offset.

Test Plan:
- Reset/idle: hold rst_in 3 cycles, then release with enable=0 for 1000 cycles → all outputs at reset values, no sample_tick, dac_cs_n stays 1.
- Single frame (CLK_DIV=2, SAMPLE_DIV=100, OSC_DAC_OFFSET_EN defined): wave=12'h000, enable=1 → captured frame is 16'h3800 (MSB first on dac_sdi); exactly 16 SCK rising edges; dac_cs_n low 64 cycles; dac_ldac_n low 2 cycles starting 2 cycles after dac_cs_n rises; busy high 68 cycles.
- Sign conversion: wave=12'h7FF → data bits 12'hFFF; wave=12'h800 → 12'h000. With OSC_DAC_OFFSET_EN undefined: wave=12'h7FF → 12'h7FF.
- Overrun: CLK_DIV=2, SAMPLE_DIV=50 (<68) → overrun sets on the 2nd tick and stays set; frames keep completing, every other tick is captured.
- Mid-frame reset: assert rst_in during SHIFT bit 7 → next cycle dac_cs_n=1, dac_sck=0, dac_ldac_n never went low, busy=0; the next frame after release is complete and correct.
- Enable drop mid-frame: clear enable during SHIFT → the frame finishes with an LDAC pulse; no further sample_tick until enable=1.

Source files
------------

// File: rtl/osc_dac_spi_tx.sv
// osc_dac_spi_tx
// Decimates the oscillator's free-running 12-bit waveform to a fixed sample
// rate and sends each sample to an MCP4921-class DAC as a 16-bit SPI frame
// {DAC_CONFIG, code}, MSB first, followed by an LDAC strobe.
//
// Build option OSC_DAC_OFFSET_EN:
//   defined   - two's-complement wave is converted to offset binary
//               (0 maps to mid-scale 0x800) before transmission
//   undefined - wave is sent unchanged, for callers that pre-offset
//
// state   | meaning
// IDLE    | waiting for a sample tick while enable is high
// SHIFT   | cs_n low, 32 SCK half-periods clock the frame out MSB first
// CS_HOLD | cs_n released, SCK parked low for one half-period
// LDAC    | ldac_n low for one half-period so the DAC output updates
//
// Every pin is driven straight from a flop; dac_sdi is the top bit of the
// shift register, which is cleared whenever no frame is being shifted.

module osc_dac_spi_tx #(
  parameter int         CLK_DIV    = 4,
  parameter int         SAMPLE_DIV = 256,
  parameter logic [3:0] DAC_CONFIG = 4'b0011
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [11:0] wave,
  input  logic        enable,
  output logic        dac_cs_n,
  output logic        dac_sck,
  output logic        dac_sdi,
  output logic        dac_ldac_n,
  output logic        busy,
  output logic        sample_tick,
  output logic        overrun
);

  localparam int PS_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(SAMPLE_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       HALF_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CS_HOLD = 2'd2,
    LDAC    = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PS_W-1:0]   ps_q;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [4:0]        half_q, half_d;
  logic [15:0]       shreg_q, shreg_d;
  logic              cs_n_d, sck_d, ldac_n_d, busy_d, sample_tick_d, overrun_d;
  logic              tick;
  logic              div_done;
  logic              half_done;
  logic [11:0]       code;

`ifdef OSC_DAC_OFFSET_EN
  assign code = {~wave[11], wave[10:0]};
`else
  assign code = wave;
`endif

  // The tick fires on the edge where the prescaler wraps back to 0.
  assign tick      = (ps_q == PS_LAST);
  assign div_done  = (div_q == '0);
  assign half_done = (half_q == '0);
  assign dac_sdi   = shreg_q[15];

  // Free-running sample prescaler, independent of enable and of the FSM.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ps_q <= '0;
    end else if (tick) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_q + 1'b1;
    end
  end

  // Next-state and next-pin logic; every pin is registered in the block below.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    half_d        = half_q;
    shreg_d       = shreg_q;
    cs_n_d        = dac_cs_n;
    sck_d         = dac_sck;
    ldac_n_d      = dac_ldac_n;
    busy_d        = busy;
    sample_tick_d = 1'b0;
    // A tick that arrives while a frame is still running (including its last
    // LDAC cycle) is dropped and remembered until reset.
    overrun_d     = overrun | (tick & enable & (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (tick && enable) begin
          state_d       = SHIFT;
          shreg_d       = {DAC_CONFIG, code};
          cs_n_d        = 1'b0;
          sck_d         = 1'b0;
          busy_d        = 1'b1;
          sample_tick_d = 1'b1;
          div_d         = DIV_LAST;
          half_d        = HALF_LAST;
        end
      end

      SHIFT: begin
        if (!div_done) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d = DIV_LAST;
          if (half_done) begin
            // Final falling edge coincides with releasing chip select.
            state_d = CS_HOLD;
            sck_d   = 1'b0;
            cs_n_d  = 1'b1;
            shreg_d = '0;
          end else begin
            half_d = half_q - 5'd1;
            sck_d  = ~dac_sck;
            // Data moves on falling edges so it is stable at the next rise.
            if (dac_sck) begin
              shreg_d = {shreg_q[14:0], 1'b0};
            end
          end
        end
      end

      CS_HOLD: begin
        if (!div_done) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          div_d    = DIV_LAST;
          state_d  = LDAC;
          ldac_n_d = 1'b0;
        end
      end

      LDAC: begin
        if (!div_done) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          state_d  = IDLE;
          ldac_n_d = 1'b1;
          busy_d   = 1'b0;
        end
      end

      default: begin
        state_d  = IDLE;
        cs_n_d   = 1'b1;
        sck_d    = 1'b0;
        ldac_n_d = 1'b1;
        busy_d   = 1'b0;
        shreg_d  = '0;
      end
    endcase
  end

  // State, timers, shift register and output pins; reset aborts any frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      div_q       <= '0;
      half_q      <= '0;
      shreg_q     <= '0;
      dac_cs_n    <= 1'b1;
      dac_sck     <= 1'b0;
      dac_ldac_n  <= 1'b1;
      busy        <= 1'b0;
      sample_tick <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      half_q      <= half_d;
      shreg_q     <= shreg_d;
      dac_cs_n    <= cs_n_d;
      dac_sck     <= sck_d;
      dac_ldac_n  <= ldac_n_d;
      busy        <= busy_d;
      sample_tick <= sample_tick_d;
      overrun     <= overrun_d;
    end
  end

endmodule

// File: tb/tb_osc_dac_spi_tx.sv
// Scoreboard bench for osc_dac_spi_tx (CLK_DIV=2, SAMPLE_DIV=50).
// A timing-level model predicts which ticks capture and which overrun and
// queues the expected frames; a pin monitor decodes each SPI frame and
// compares it with the queue head. Works with or without OSC_DAC_OFFSET_EN.
module tb_osc_dac_spi_tx;

  localparam int         CD        = 2;
  localparam int         SD        = 50;
  localparam logic [3:0] CFG       = 4'b0011;
  localparam int         FRAME_CYC = 34 * CD;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable = 1'b0;
  logic [11:0] wave   = 12'h000;
  logic        dac_cs_n, dac_sck, dac_sdi, dac_ldac_n, busy, sample_tick, overrun;

  osc_dac_spi_tx #(
    .CLK_DIV    (CD),
    .SAMPLE_DIV (SD),
    .DAC_CONFIG (CFG)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .wave        (wave),
    .enable      (enable),
    .dac_cs_n    (dac_cs_n),
    .dac_sck     (dac_sck),
    .dac_sdi     (dac_sdi),
    .dac_ldac_n  (dac_ldac_n),
    .busy        (busy),
    .sample_tick (sample_tick),
    .overrun     (overrun)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [15:0] frame;
    int          cap_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected DAC code: adding half-scale modulo 4096 moves two's complement
  // into offset binary.
  function automatic logic [11:0] ref_code(input logic [11:0] w);
`ifdef OSC_DAC_OFFSET_EN
    return w + 12'h800;
`else
    return w;
`endif
  endfunction

  int cyc     = 0;   // clock edges since reset released
  int free_at = 0;   // first edge at which the transmitter is idle again
  bit mdl_ovr = 1'b0;

  always @(posedge clk_in) begin
    if (rst_in) begin
      cyc     = 0;
      free_at = 0;
      mdl_ovr = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      if ((cyc % SD) == 0 && enable) begin
        if (cyc >= free_at) begin
          exp_q.push_back('{frame: {CFG, ref_code(wave)}, cap_cyc: cyc});
          free_at = cyc + FRAME_CYC + 1;
        end else begin
          mdl_ovr = 1'b1;
        end
      end
    end
  end

  // ---------------- pin monitor ----------------
  bit          in_frame = 1'b0;
  bit          have_cur = 1'b0;
  exp_t        cur;
  int          fcyc, busy_cnt, cs_cnt, rise_cnt, fall_cnt, ldac_cnt;
  int          cs_rise_fc, ldac_fall_fc;
  logic [15:0] bits;
  logic        prev_sck = 1'b0;

  always @(negedge clk_in) begin
    if (rst_in) begin
      in_frame = 1'b0;
      prev_sck = 1'b0;
    end else begin
      check("overrun_flag", overrun, mdl_ovr);
      if (sample_tick) begin
        check("tick_expected", exp_q.size() != 0, 1);
        check("tick_overlap", in_frame, 0);
        have_cur = (exp_q.size() != 0);
        if (have_cur) begin
          cur = exp_q.pop_front();
          check("capture_cycle", cyc, cur.cap_cyc);
          check("sdi_first_bit", dac_sdi, cur.frame[15]);
        end
        in_frame     = 1'b1;
        fcyc         = 0;
        busy_cnt     = 0;
        cs_cnt       = 0;
        rise_cnt     = 0;
        fall_cnt     = 0;
        ldac_cnt     = 0;
        cs_rise_fc   = -1;
        ldac_fall_fc = -1;
        bits         = '0;
      end
      if (in_frame) begin
        if (busy) begin
          busy_cnt++;
          if (!dac_cs_n) cs_cnt++;
          else if (cs_rise_fc < 0) cs_rise_fc = fcyc;
          if (dac_sck && !prev_sck) begin
            rise_cnt++;
            bits = {bits[14:0], dac_sdi};
          end
          if (!dac_sck && prev_sck) fall_cnt++;
          if (!dac_ldac_n) begin
            ldac_cnt++;
            if (ldac_fall_fc < 0) ldac_fall_fc = fcyc;
          end
          fcyc++;
        end else begin
          if (have_cur) check("frame_data", bits, cur.frame);
          check("sck_rises", rise_cnt, 16);
          check("sck_falls", fall_cnt, 16);
          check("cs_low_cycles", cs_cnt, 32 * CD);
          check("busy_cycles", busy_cnt, FRAME_CYC);
          check("ldac_cycles", ldac_cnt, CD);
          check("ldac_after_cs", ldac_fall_fc - cs_rise_fc, CD);
          in_frame = 1'b0;
        end
      end else begin
        check("idle_pins", {busy, dac_cs_n, dac_sck, dac_sdi, dac_ldac_n}, 5'b01001);
      end
      prev_sck = dac_sck;
    end
  end

  // ---------------- stimulus ----------------
  bit wave_rand = 1'b1;

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk_in);
      if (wave_rand) wave = 12'($urandom);
    end
  endtask

  task automatic wait_tick(input int max, input string name);
    bit seen = 1'b0;
    for (int k = 0; k < max && !seen; k++) begin
      step(1);
      seen = sample_tick;
    end
    check(name, seen, 1);
  endtask

  task automatic wait_idle(input int max, input string name);
    bit done = 1'b0;
    for (int k = 0; k < max && !done; k++) begin
      step(1);
      done = !busy;
    end
    check(name, done, 1);
  endtask

  task automatic do_reset(input int n);
    rst_in = 1'b1;
    step(n);
    check("reset_pins", {dac_cs_n, dac_sck, dac_sdi, dac_ldac_n, busy, sample_tick, overrun},
          7'b1001000);
    rst_in = 1'b0;
  endtask

  initial begin
    logic [11:0] dir_w [5];
    int          rises;
    int          ntick;
    bit          ldac_seen;
    logic        prv;

    dir_w = '{12'h000, 12'h7FF, 12'h800, 12'h123, 12'hFFF};
    @(negedge clk_in);

    // reset, then a long idle stretch with enable low
    do_reset(3);
    step(1000);
    check("idle_after_1000", {dac_cs_n, dac_sck, dac_sdi, dac_ldac_n, busy, sample_tick, overrun},
          7'b1001000);

    // directed samples; enable dropped as soon as the frame starts
    for (int i = 0; i < 5; i++) begin
      wave_rand = 1'b0;
      wave      = dir_w[i];
      enable    = 1'b1;
      wait_tick(2 * SD, "tick_directed");
      enable    = 1'b0;
      wave_rand = 1'b1;
      wait_idle(FRAME_CYC + 10, "frame_done_directed");
      step(SD);
    end

    // random samples, enable dropped at a random point inside the frame
    for (int i = 0; i < 6; i++) begin
      enable = 1'b1;
      wait_tick(2 * SD, "tick_random");
      step($urandom_range(1, SD - 5));
      enable = 1'b0;
      wait_idle(FRAME_CYC + 10, "frame_done_random");
      step(SD + $urandom_range(0, SD));
    end

    // reset during bit 7 of a frame
    enable = 1'b1;
    wait_tick(2 * SD, "tick_before_abort");
    enable    = 1'b0;
    rises     = 0;
    ldac_seen = 1'b0;
    prv       = dac_sck;
    for (int k = 0; k < FRAME_CYC && rises < 9; k++) begin
      step(1);
      if (dac_sck && !prv) rises++;
      if (!dac_ldac_n) ldac_seen = 1'b1;
      prv = dac_sck;
    end
    check("abort_reached_bit7", rises, 9);
    rst_in = 1'b1;
    step(1);
    check("abort_pins", {dac_cs_n, dac_sck, dac_ldac_n, busy}, 4'b1010);
    check("abort_no_ldac", ldac_seen, 0);
    step(1);
    rst_in = 1'b0;
    enable = 1'b1;
    wait_tick(2 * SD, "tick_after_abort");
    enable = 1'b0;
    wait_idle(FRAME_CYC + 10, "frame_done_after_abort");
    step(SD);

    // continuous enable with frames longer than the tick period
    enable = 1'b1;
    ntick  = 0;
    for (int k = 0; k < 12 * SD; k++) begin
      step(1);
      if (sample_tick) ntick++;
    end
    check("overrun_captures", ntick, 6);
    check("overrun_sticky", overrun, 1);
    enable = 1'b0;
    wait_idle(FRAME_CYC + 10, "frame_done_overrun");
    step(SD);

    // fully random enable pattern
    do_reset(2);
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 3) != 0);
      step(1);
    end
    enable = 1'b0;
    wait_idle(FRAME_CYC + 10, "frame_done_final");
    step(SD);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
